// File: rtl/mod_addsub_step_pipe.sv
// Purpose : elastic 2-stage pipelined (A +/- STEP) mod MODULUS for one residue digit,
//           with wrap/range-error flags and a saturating count of errored results.
// Ports   : clk/reset (async, active-high); in_valid/in_ready/in_a/in_step/in_sub input handshake;
//           out_valid/out_ready/out_result/out_wrap/out_err output handshake; err_count saturating counter.
// Latency : 2 cycles accept->out_valid, 1 transaction/cycle; stalls propagate back through stage enables.
module mod_addsub_step_pipe #(
  parameter int DATA_WIDTH = 18,
  parameter int MODULUS    = 177147,
  parameter int ERRCNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_step,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_wrap,
  output logic                  out_err,
  output logic [ERRCNT_W-1:0]   err_count
);

  localparam int W = DATA_WIDTH;
  // One extra bit so that M = 2**W and the add/sub intermediates are representable.
  localparam logic [W:0]          MOD     = (W+1)'(MODULUS);
  localparam logic [ERRCNT_W-1:0] ERR_MAX = '1;

  // ---------------------------------------------------------------------------
  // Stage enables: a stage may load when it is empty or its contents move on.
  // ---------------------------------------------------------------------------
  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  logic en1, en2;

  assign en2      = !s2_vld_q || out_ready;
  assign en1      = !s1_vld_q || en2;
  assign in_ready = en1;

  // ---------------------------------------------------------------------------
  // Stage 1: raw sum/difference and operand range check.
  // ---------------------------------------------------------------------------
  logic [W:0] s1_raw_q, s1_raw_d;
  logic       s1_err_q, s1_err_d;
  logic       s1_sub_q, s1_sub_d;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_raw_d = s1_raw_q;
    s1_err_d = s1_err_q;
    s1_sub_d = s1_sub_q;
    if (en1) begin
      s1_vld_d = in_valid;
      // Data registers only load on a real transaction; a bubble needs no payload.
      if (in_valid) begin
        s1_raw_d = in_sub ? ({1'b0, in_a} - {1'b0, in_step})
                          : ({1'b0, in_a} + {1'b0, in_step});
        s1_err_d = ({1'b0, in_a} >= MOD) || ({1'b0, in_step} >= MOD);
        s1_sub_d = in_sub;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_raw_q <= '0;
      s1_err_q <= 1'b0;
      s1_sub_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_raw_q <= s1_raw_d;
      s1_err_q <= s1_err_d;
      s1_sub_q <= s1_sub_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: single conditional correction by +/-M brings raw back into 0..M-1.
  // ---------------------------------------------------------------------------
  logic [W:0]   add_fix, sub_fix;
  logic [W-1:0] s2_res_q, s2_res_d;
  logic         s2_wrap_q, s2_wrap_d;
  logic         s2_err_q, s2_err_d;
  logic [W-1:0] fix_res;
  logic         fix_wrap;

  assign add_fix = s1_raw_q - MOD;
  // A negative difference is two's complement in W+1 bits; adding M and keeping
  // the low W bits yields A-STEP+M.
  assign sub_fix = s1_raw_q + MOD;

  always_comb begin
    fix_res  = s1_raw_q[W-1:0];
    fix_wrap = 1'b0;
    if (s1_err_q) begin
      fix_res  = '0;
    end else if (s1_sub_q) begin
      if (s1_raw_q[W]) begin
        fix_res  = sub_fix[W-1:0];
        fix_wrap = 1'b1;
      end
    end else begin
      if (s1_raw_q >= MOD) begin
        fix_res  = add_fix[W-1:0];
        fix_wrap = 1'b1;
      end
    end
  end

  always_comb begin
    s2_vld_d  = s2_vld_q;
    s2_res_d  = s2_res_q;
    s2_wrap_d = s2_wrap_q;
    s2_err_d  = s2_err_q;
    if (en2) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_res_d  = fix_res;
        s2_wrap_d = fix_wrap;
        s2_err_d  = s1_err_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld_q  <= 1'b0;
      s2_res_q  <= '0;
      s2_wrap_q <= 1'b0;
      s2_err_q  <= 1'b0;
    end else begin
      s2_vld_q  <= s2_vld_d;
      s2_res_q  <= s2_res_d;
      s2_wrap_q <= s2_wrap_d;
      s2_err_q  <= s2_err_d;
    end
  end

  assign out_valid  = s2_vld_q;
  assign out_result = s2_res_q;
  assign out_wrap   = s2_wrap_q;
  assign out_err    = s2_err_q;

  // ---------------------------------------------------------------------------
  // Error counter: counts errored results as they are consumed, sticks at max.
  // ---------------------------------------------------------------------------
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_vld_q && out_ready && s2_err_q && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;

endmodule
